wrf_frame_checker: RTL

WRF_FRAME_CHECKER -- requirements
Module: wrf_frame_checker

---
 rtl/wrf_frame_checker.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wrf_frame_checker.sv
// wrf_frame_checker
// Fabric sink that accepts Ethernet frames as 16-bit big-endian words,
// checks header length, declared length, payload test pattern and status
// beats, and keeps per-frame results plus saturating frame/error counters.
// rst_n is the block's asynchronous reset and is active-high.

module wrf_frame_checker #(
  parameter int g_rand_stall = 0,
  parameter int g_max_len    = 1518
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        snk_cyc_i,
  input  logic        snk_stb_i,
  input  logic        snk_we_i,
  input  logic [1:0]  snk_adr_i,
  input  logic [1:0]  snk_sel_i,
  input  logic [15:0] snk_dat_i,
  output logic        snk_ack_o,
  output logic        snk_stall_o,
  output logic        snk_err_o,
  input  logic        clr_i,
  output logic        frame_done_o,
  output logic        frame_ok_o,
  output logic [31:0] frame_cnt_o,
  output logic [31:0] err_cnt_o,
  output logic [15:0] last_len_o,
  output logic [15:0] last_type_o,
  output logic        hdr_err_o,
  output logic        len_err_o,
  output logic        pat_err_o,
  output logic        stat_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam logic [15:0] MAX_LEN    = 16'(g_max_len);
  localparam logic        RAND_STALL = (g_rand_stall != 0);
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] HDR_BYTES  = 16'd14;
  localparam logic [15:0] MAX_TYPE_LEN = 16'd1500;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // 32-bit increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  // Payload test word n: bytes 2n and 2n+1, modulo 256. Only n[6:0] matters.
  function automatic logic [15:0] pat_word(input logic [6:0] n);
    return {n, 1'b0, n, 1'b1};
  endfunction

  state_t      state_r, state_s;
  logic        cyc_d_r;
  logic        first_r;
  logic [15:0] lfsr_r;
  logic        ack_r;
  logic [15:0] word_cnt_r, word_cnt_s;
  logic [15:0] byte_cnt_r, byte_cnt_s;
  logic [15:0] etype_r, etype_s;
  logic        fpat_r, fpat_s;
  logic        fstat_r, fstat_s;

  logic        frame_done_r, frame_ok_r;
  logic [31:0] frame_cnt_r, err_cnt_r;
  logic [15:0] last_len_r, last_type_r;
  logic        hdr_err_r, len_err_r, pat_err_r, stat_err_r;

  logic        stall_s, accept_s, rise_s, start_s, in_frame_s, close_s;
  logic        data_beat_s, stat_beat_s;
  logic [15:0] wc_base_s, bc_base_s;
  logic        pat_base_s, stat_base_s;
  logic [1:0]  byte_inc_s;
  logic [16:0] bc_sum_s;
  logic [6:0]  pay_idx_s;
  logic [15:0] exp_word_s;
  logic        pat_miss_s;
  logic        hdr_e_s, len_e_s, frame_err_s;
  logic [15:0] len_sub_s;

  // Stall comes from the LFSR only while a cycle is open and not in reset.
  assign stall_s     = RAND_STALL & lfsr_r[0] & snk_cyc_i & ~rst_n;
  assign accept_s    = snk_cyc_i & snk_stb_i & ~stall_s;
  assign rise_s      = snk_cyc_i & ~cyc_d_r;
  assign start_s     = (state_r == ST_IDLE) & rise_s & ~first_r;
  assign in_frame_s  = start_s | (state_r == ST_HDR) | (state_r == ST_PAYLOAD);
  assign close_s     = ((state_r == ST_HDR) | (state_r == ST_PAYLOAD)) & ~snk_cyc_i;
  assign data_beat_s = accept_s & snk_we_i & (snk_adr_i == 2'b00) & in_frame_s;
  assign stat_beat_s = accept_s & snk_we_i & (snk_adr_i == 2'b10) & in_frame_s;

  // A frame starting this cycle sees cleared counters and error bits.
  assign wc_base_s   = start_s ? 16'd0 : word_cnt_r;
  assign bc_base_s   = start_s ? 16'd0 : byte_cnt_r;
  assign pat_base_s  = start_s ? 1'b0  : fpat_r;
  assign stat_base_s = start_s ? 1'b0  : fstat_r;
  assign pay_idx_s   = wc_base_s[6:0] - 7'd7;
  assign exp_word_s  = pat_word(pay_idx_s);
  assign bc_sum_s    = {1'b0, bc_base_s} + {15'd0, byte_inc_s};

  // Close-time verdict, evaluated from the settled frame registers.
  assign len_sub_s   = byte_cnt_r - HDR_BYTES;
  assign hdr_e_s     = (byte_cnt_r < HDR_BYTES);
  assign len_e_s     = (byte_cnt_r > MAX_LEN) |
                       ((etype_r <= MAX_TYPE_LEN) & (len_sub_s != etype_r));
  assign frame_err_s = hdr_e_s | len_e_s | fpat_r | fstat_r;

  // Bytes carried by one data beat, from the byte select.
  always_comb begin
    byte_inc_s = 2'd0;
    case (snk_sel_i)
      2'b11:   byte_inc_s = 2'd2;
      2'b10:   byte_inc_s = 2'd1;
      default: byte_inc_s = 2'd0;
    endcase
  end

  // Payload pattern compare; an upper-byte-only beat checks the upper byte.
  always_comb begin
    pat_miss_s = 1'b0;
    if (data_beat_s && (wc_base_s >= 16'd7)) begin
      case (snk_sel_i)
        2'b11:   pat_miss_s = (snk_dat_i != exp_word_s);
        2'b10:   pat_miss_s = (snk_dat_i[15:8] != exp_word_s[15:8]);
        default: pat_miss_s = 1'b0;
      endcase
    end else begin
      pat_miss_s = 1'b0;
    end
  end

  // Next values of the per-frame word/byte counters, ethertype and error bits.
  always_comb begin
    word_cnt_s = wc_base_s;
    byte_cnt_s = bc_base_s;
    etype_s    = start_s ? 16'd0 : etype_r;
    fpat_s     = pat_base_s | pat_miss_s;
    fstat_s    = stat_base_s;
    if (data_beat_s) begin
      word_cnt_s = (wc_base_s == 16'hFFFF) ? wc_base_s : (wc_base_s + 16'd1);
      byte_cnt_s = bc_sum_s[16] ? 16'hFFFF : bc_sum_s[15:0];
      if (wc_base_s == 16'd6) begin
        etype_s = snk_dat_i;
      end else begin
        etype_s = start_s ? 16'd0 : etype_r;
      end
    end else begin
      word_cnt_s = wc_base_s;
      byte_cnt_s = bc_base_s;
    end
    if (stat_beat_s) begin
      fstat_s = stat_base_s | snk_dat_i[1];
    end else begin
      fstat_s = stat_base_s;
    end
  end

  // Frame FSM next state: header words 0-6, then payload until cyc falls.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (first_r && snk_cyc_i) begin
          state_s = ST_FLUSH;
        end else if (start_s) begin
          state_s = ST_HDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (!snk_cyc_i) begin
          state_s = ST_IDLE;
        end else if (data_beat_s && (wc_base_s == 16'd6)) begin
          state_s = ST_PAYLOAD;
        end else begin
          state_s = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        if (!snk_cyc_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PAYLOAD;
        end
      end
      ST_FLUSH: begin
        if (!snk_cyc_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, cyc edge history and the first-cycle-after-reset marker.
  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) begin
      state_r <= ST_IDLE;
      cyc_d_r <= 1'b0;
      first_r <= 1'b1;
    end else begin
      state_r <= state_s;
      cyc_d_r <= snk_cyc_i;
      first_r <= 1'b0;
    end
  end

  // Stall LFSR free-runs every cycle; ack follows each accepted beat.
  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) begin
      lfsr_r <= LFSR_SEED;
      ack_r  <= 1'b0;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
      ack_r  <= accept_s;
    end
  end

  // Per-frame accumulation registers.
  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) begin
      word_cnt_r <= 16'd0;
      byte_cnt_r <= 16'd0;
      etype_r    <= 16'd0;
      fpat_r     <= 1'b0;
      fstat_r    <= 1'b0;
    end else begin
      word_cnt_r <= word_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      etype_r    <= etype_s;
      fpat_r     <= fpat_s;
      fstat_r    <= fstat_s;
    end
  end

  // Frame result, last-frame info, counters and sticky flags; clear beats close.
  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) begin
      frame_done_r <= 1'b0;
      frame_ok_r   <= 1'b0;
      last_len_r   <= 16'd0;
      last_type_r  <= 16'd0;
      frame_cnt_r  <= 32'd0;
      err_cnt_r    <= 32'd0;
      hdr_err_r    <= 1'b0;
      len_err_r    <= 1'b0;
      pat_err_r    <= 1'b0;
      stat_err_r   <= 1'b0;
    end else begin
      frame_done_r <= close_s;
      if (close_s) begin
        frame_ok_r  <= ~frame_err_s;
        last_len_r  <= byte_cnt_r;
        last_type_r <= etype_r;
      end else begin
        frame_ok_r  <= frame_ok_r;
        last_len_r  <= last_len_r;
        last_type_r <= last_type_r;
      end
      if (clr_i) begin
        frame_cnt_r <= 32'd0;
        err_cnt_r   <= 32'd0;
        hdr_err_r   <= 1'b0;
        len_err_r   <= 1'b0;
        pat_err_r   <= 1'b0;
        stat_err_r  <= 1'b0;
      end else if (close_s) begin
        frame_cnt_r <= sat_inc32(frame_cnt_r);
        err_cnt_r   <= frame_err_s ? sat_inc32(err_cnt_r) : err_cnt_r;
        hdr_err_r   <= hdr_err_r  | hdr_e_s;
        len_err_r   <= len_err_r  | len_e_s;
        pat_err_r   <= pat_err_r  | fpat_r;
        stat_err_r  <= stat_err_r | fstat_r;
      end else begin
        frame_cnt_r <= frame_cnt_r;
        err_cnt_r   <= err_cnt_r;
        hdr_err_r   <= hdr_err_r;
        len_err_r   <= len_err_r;
        pat_err_r   <= pat_err_r;
        stat_err_r  <= stat_err_r;
      end
    end
  end

  assign snk_ack_o    = ack_r;
  assign snk_stall_o  = stall_s;
  assign snk_err_o    = 1'b0;
  assign frame_done_o = frame_done_r;
  assign frame_ok_o   = frame_ok_r;
  assign frame_cnt_o  = frame_cnt_r;
  assign err_cnt_o    = err_cnt_r;
  assign last_len_o   = last_len_r;
  assign last_type_o  = last_type_r;
  assign hdr_err_o    = hdr_err_r;
  assign len_err_o    = len_err_r;
  assign pat_err_o    = pat_err_r;
  assign stat_err_o   = stat_err_r;

endmodule
